// File: rtl/cache.sv
// rtl/cache.sv - split L1 cache (I + D) with true-LRU replacement and MESI coherence
module cache #(
    parameter int SETS       = 16384,
    parameter int LINE_BYTES = 64,
    parameter int DWAYS      = 8,
    parameter int IWAYS      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [35:0] address,
    input  logic        mode,
    input  logic [31:0] iteration,
    output logic        l2_wb_valid,
    output logic [31:0] l2_wb_addr,
    output logic        l2_msg_valid,
    output logic [1:0]  l2_msg_code,
    output logic [31:0] l2_msg_addr,
    output logic [31:0] d_reads,
    output logic [31:0] d_writes,
    output logic [31:0] d_hits,
    output logic [31:0] d_misses,
    output logic [31:0] i_reads,
    output logic [31:0] i_hits,
    output logic [31:0] i_misses
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam int DR_W  = $clog2(DWAYS);
    localparam int IR_W  = $clog2(IWAYS);
    localparam logic [1:0] MSG_READ = 2'd0, MSG_WRITE = 2'd1, MSG_RFO = 2'd2, MSG_RET = 2'd3;

    typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3} mesi_e;

    // Whole-set rows; a set whose valid bit is clear reads as all-I with ranks = way index,
    // so reset and clear only touch the valid vectors.
    logic [DWAYS*TAG_W-1:0] dtag_q [SETS];
    logic [DWAYS*2-1:0]     dst_q  [SETS];
    logic [DWAYS*DR_W-1:0]  drk_q  [SETS];
    logic [IWAYS*TAG_W-1:0] itag_q [SETS];
    logic [IWAYS*2-1:0]     ist_q  [SETS];
    logic [IWAYS*IR_W-1:0]  irk_q  [SETS];
    logic [SETS-1:0]        dvld_q, ivld_q;

    logic [31:0] d_reads_q, d_writes_q, d_hits_q, d_misses_q, i_reads_q, i_hits_q, i_misses_q;
    logic        wb_v_q, msg_v_q, wb_v_d, msg_v_d;
    logic [31:0] wb_a_q, msg_a_q, wb_a_d, msg_a_d;
    logic [1:0]  msg_c_q, msg_c_d;

    logic [3:0]       code;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [31:0]      line_addr;
    logic             unused_bits;

    assign code        = address[35:32];
    assign idx         = address[OFF_W+IDX_W-1:OFF_W];
    assign tag         = address[31:OFF_W+IDX_W];
    assign line_addr   = {address[31:OFF_W], {OFF_W{1'b0}}};
    assign unused_bits = ^{iteration, address[OFF_W-1:0]};

    logic [DWAYS*TAG_W-1:0] d_tag_row, d_tag_new;
    logic [DWAYS*2-1:0]     d_st_row, d_st_new;
    logic [DWAYS*DR_W-1:0]  d_rk_row, d_rk_new;
    logic                   d_hit, d_inv, d_we, d_touch;
    logic [DR_W-1:0]        d_hway, d_iway, d_lway, d_way, d_rank;
    logic [TAG_W-1:0]       d_vtag;
    mesi_e                  d_state, d_fill_st;

    logic [IWAYS*TAG_W-1:0] i_tag_row, i_tag_new;
    logic [IWAYS*2-1:0]     i_st_row, i_st_new;
    logic [IWAYS*IR_W-1:0]  i_rk_row, i_rk_new;
    logic                   i_hit, i_inv, i_we;
    logic [IR_W-1:0]        i_hway, i_iway, i_lway, i_way, i_rank;

    // D-cache lookup: hit way, lowest invalid way, LRU way of the addressed set
    always_comb begin
        d_tag_row = dtag_q[idx];
        d_st_row  = dvld_q[idx] ? dst_q[idx] : '0;
        d_rk_row  = '0;
        d_hit = 1'b0; d_hway = '0; d_inv = 1'b0; d_iway = '0; d_lway = '0;
        for (int w = 0; w < DWAYS; w++)
            d_rk_row[w*DR_W +: DR_W] = dvld_q[idx] ? drk_q[idx][w*DR_W +: DR_W] : DR_W'(w);
        for (int w = DWAYS - 1; w >= 0; w--) begin
            if (d_st_row[w*2 +: 2] == ST_I) begin
                d_inv = 1'b1; d_iway = DR_W'(w);
            end else if (d_tag_row[w*TAG_W +: TAG_W] == tag) begin
                d_hit = 1'b1; d_hway = DR_W'(w);
            end
            if (d_rk_row[w*DR_W +: DR_W] == DR_W'(DWAYS - 1)) d_lway = DR_W'(w);
        end
        d_way   = d_hit ? d_hway : (d_inv ? d_iway : d_lway);
        d_state = mesi_e'(d_st_row[int'(d_way)*2 +: 2]);
        d_rank  = d_rk_row[int'(d_way)*DR_W +: DR_W];
        d_vtag  = d_tag_row[int'(d_way)*TAG_W +: TAG_W];
    end

    // I-cache lookup, same scheme with its own associativity
    always_comb begin
        i_tag_row = itag_q[idx];
        i_st_row  = ivld_q[idx] ? ist_q[idx] : '0;
        i_rk_row  = '0;
        i_hit = 1'b0; i_hway = '0; i_inv = 1'b0; i_iway = '0; i_lway = '0;
        for (int w = 0; w < IWAYS; w++)
            i_rk_row[w*IR_W +: IR_W] = ivld_q[idx] ? irk_q[idx][w*IR_W +: IR_W] : IR_W'(w);
        for (int w = IWAYS - 1; w >= 0; w--) begin
            if (i_st_row[w*2 +: 2] == ST_I) begin
                i_inv = 1'b1; i_iway = IR_W'(w);
            end else if (i_tag_row[w*TAG_W +: TAG_W] == tag) begin
                i_hit = 1'b1; i_hway = IR_W'(w);
            end
            if (i_rk_row[w*IR_W +: IR_W] == IR_W'(IWAYS - 1)) i_lway = IR_W'(w);
        end
        i_way  = i_hit ? i_hway : (i_inv ? i_iway : i_lway);
        i_rank = i_rk_row[int'(i_way)*IR_W +: IR_W];
    end

    // Command decode: new set rows plus the L2 traffic this command generates
    always_comb begin
        d_we = 1'b0; d_touch = 1'b0; d_fill_st = ST_I; i_we = 1'b0;
        d_tag_new = d_tag_row; d_st_new = d_st_row; d_rk_new = d_rk_row;
        i_tag_new = i_tag_row; i_st_new = i_st_row; i_rk_new = i_rk_row;
        wb_v_d  = 1'b0; wb_a_d = {d_vtag, idx, {OFF_W{1'b0}}};
        msg_v_d = 1'b0; msg_c_d = MSG_READ; msg_a_d = line_addr;
        if (cmd_valid) begin
            case (code)
                4'd0: begin
                    d_touch   = 1'b1;
                    d_fill_st = d_hit ? d_state : ST_E;
                    if (!d_hit) begin
                        wb_v_d  = (d_state == ST_M);
                        msg_v_d = 1'b1;
                    end
                end
                4'd1: begin
                    d_touch   = 1'b1;
                    d_fill_st = ST_M;
                    if (!d_hit) begin
                        wb_v_d  = (d_state == ST_M);
                        msg_v_d = 1'b1; msg_c_d = MSG_RFO;
                    end else if (d_state == ST_S) begin
                        msg_v_d = 1'b1; msg_c_d = MSG_WRITE;
                    end
                end
                4'd2: begin
                    i_we = 1'b1;
                    if (!i_hit) msg_v_d = 1'b1;
                end
                4'd3: if (d_hit && d_state == ST_S) begin
                    d_we = 1'b1;
                    d_st_new[int'(d_way)*2 +: 2] = ST_I;
                end
                4'd4: if (d_hit && (d_state == ST_M || d_state == ST_E)) begin
                    d_we = 1'b1;
                    d_st_new[int'(d_way)*2 +: 2] = ST_S;
                    if (d_state == ST_M) begin
                        msg_v_d = 1'b1; msg_c_d = MSG_RET;
                    end
                end
                default: ;
            endcase
        end
        if (d_touch) begin
            d_we = 1'b1;
            d_tag_new[int'(d_way)*TAG_W +: TAG_W] = tag;
            d_st_new[int'(d_way)*2 +: 2] = d_fill_st;
            for (int w = 0; w < DWAYS; w++) begin
                if (w == int'(d_way))                       d_rk_new[w*DR_W +: DR_W] = '0;
                else if (d_rk_row[w*DR_W +: DR_W] < d_rank) d_rk_new[w*DR_W +: DR_W] = d_rk_row[w*DR_W +: DR_W] + 1'b1;
            end
        end
        if (i_we) begin
            i_tag_new[int'(i_way)*TAG_W +: TAG_W] = tag;
            i_st_new[int'(i_way)*2 +: 2] = ST_E;
            for (int w = 0; w < IWAYS; w++) begin
                if (w == int'(i_way))                       i_rk_new[w*IR_W +: IR_W] = '0;
                else if (i_rk_row[w*IR_W +: IR_W] < i_rank) i_rk_new[w*IR_W +: IR_W] = i_rk_row[w*IR_W +: IR_W] + 1'b1;
            end
        end
    end

    // Set-row storage; contents are only meaningful once the set's valid bit is set
    always_ff @(posedge clk) begin
        if (!reset && d_we) begin
            dtag_q[idx] <= d_tag_new; dst_q[idx] <= d_st_new; drk_q[idx] <= d_rk_new;
        end
        if (!reset && i_we) begin
            itag_q[idx] <= i_tag_new; ist_q[idx] <= i_st_new; irk_q[idx] <= i_rk_new;
        end
    end

    // Set-valid vectors, statistics counters and registered L2 outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvld_q <= '0; ivld_q <= '0;
            d_reads_q <= '0; d_writes_q <= '0; d_hits_q <= '0; d_misses_q <= '0;
            i_reads_q <= '0; i_hits_q <= '0; i_misses_q <= '0;
            wb_v_q <= 1'b0; wb_a_q <= '0; msg_v_q <= 1'b0; msg_c_q <= '0; msg_a_q <= '0;
        end else begin
            wb_v_q  <= wb_v_d & mode;
            wb_a_q  <= wb_a_d;
            msg_v_q <= msg_v_d & mode;
            msg_c_q <= msg_c_d;
            msg_a_q <= msg_a_d;
            if (d_we) dvld_q[idx] <= 1'b1;
            if (i_we) ivld_q[idx] <= 1'b1;
            if (cmd_valid) begin
                case (code)
                    4'd0: begin
                        d_reads_q <= d_reads_q + 1'b1;
                        if (d_hit) d_hits_q <= d_hits_q + 1'b1; else d_misses_q <= d_misses_q + 1'b1;
                    end
                    4'd1: begin
                        d_writes_q <= d_writes_q + 1'b1;
                        if (d_hit) d_hits_q <= d_hits_q + 1'b1; else d_misses_q <= d_misses_q + 1'b1;
                    end
                    4'd2: begin
                        i_reads_q <= i_reads_q + 1'b1;
                        if (i_hit) i_hits_q <= i_hits_q + 1'b1; else i_misses_q <= i_misses_q + 1'b1;
                    end
                    4'd8: begin
                        dvld_q <= '0; ivld_q <= '0;
                        d_reads_q <= '0; d_writes_q <= '0; d_hits_q <= '0; d_misses_q <= '0;
                        i_reads_q <= '0; i_hits_q <= '0; i_misses_q <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign l2_wb_valid  = wb_v_q;
    assign l2_wb_addr   = wb_a_q;
    assign l2_msg_valid = msg_v_q;
    assign l2_msg_code  = msg_c_q;
    assign l2_msg_addr  = msg_a_q;
    assign d_reads      = d_reads_q;
    assign d_writes     = d_writes_q;
    assign d_hits       = d_hits_q;
    assign d_misses     = d_misses_q;
    assign i_reads      = i_reads_q;
    assign i_hits       = i_hits_q;
    assign i_misses     = i_misses_q;
endmodule

// File: tb/tb_cache.sv
// tb/tb_cache.sv - directed self-checking bench for the split L1 cache
module tb_cache;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [35:0] address = '0;
    logic        mode = 1'b1;
    logic [31:0] iteration = '0;
    logic        l2_wb_valid, l2_msg_valid;
    logic [31:0] l2_wb_addr, l2_msg_addr;
    logic [1:0]  l2_msg_code;
    logic [31:0] d_reads, d_writes, d_hits, d_misses, i_reads, i_hits, i_misses;

    int n_checks = 0;
    int n_fail   = 0;

    cache dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .address(address), .mode(mode),
        .iteration(iteration), .l2_wb_valid(l2_wb_valid), .l2_wb_addr(l2_wb_addr),
        .l2_msg_valid(l2_msg_valid), .l2_msg_code(l2_msg_code), .l2_msg_addr(l2_msg_addr),
        .d_reads(d_reads), .d_writes(d_writes), .d_hits(d_hits), .d_misses(d_misses),
        .i_reads(i_reads), .i_hits(i_hits), .i_misses(i_misses)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic do_cmd(input logic [3:0] c, input logic [31:0] a);
        @(negedge clk);
        cmd_valid = 1'b1; address = {c, a}; iteration = iteration + 1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        cmd_valid = 1'b1; address = {4'd0, 32'h40}; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0;
        #1;
        n_checks++;
        if ({d_reads, d_writes, d_hits, d_misses, i_reads, i_hits, i_misses} !== '0) begin
            n_fail++; $display("FAIL reset_counters got %0d/%0d/%0d/%0d exp 0", d_reads, d_misses, i_reads, i_misses);
        end
        n_checks++;
        if ({l2_wb_valid, l2_msg_valid, l2_wb_addr, l2_msg_addr, l2_msg_code} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got wb=%0b msg=%0b exp 0", l2_wb_valid, l2_msg_valid);
        end
    endtask

    task automatic test_read_hit();
        do_cmd(4'd0, 32'h0000_0040);
        n_checks++;
        if (l2_msg_valid !== 1'b1 || l2_msg_code !== 2'd0 || l2_msg_addr !== 32'h40 || l2_wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_miss_msg got v=%0b c=%0d a=%h wb=%0b exp v=1 c=0 a=00000040 wb=0",
                               l2_msg_valid, l2_msg_code, l2_msg_addr, l2_wb_valid);
        end
        do_cmd(4'd0, 32'h0000_0040);
        n_checks++;
        if (l2_msg_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd_hit_nomsg got %0b exp 0", l2_msg_valid);
        end
        n_checks++;
        if (d_reads !== 32'd2 || d_hits !== 32'd1 || d_misses !== 32'd1) begin
            n_fail++; $display("FAIL rd_counters got r=%0d h=%0d m=%0d exp r=2 h=1 m=1", d_reads, d_hits, d_misses);
        end
    endtask

    task automatic test_evict();
        do_reset();
        do_cmd(4'd1, 32'h0000_0000);
        n_checks++;
        if (l2_msg_valid !== 1'b1 || l2_msg_code !== 2'd2 || l2_msg_addr !== 32'h0) begin
            n_fail++; $display("FAIL ev_rfo got v=%0b c=%0d a=%h exp v=1 c=2 a=00000000", l2_msg_valid, l2_msg_code, l2_msg_addr);
        end
        for (int k = 1; k < 8; k++) do_cmd(4'd0, k << 20);
        n_checks++;
        if (l2_wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL ev_fill_nowb got %0b exp 0", l2_wb_valid);
        end
        do_cmd(4'd0, 32'h0080_0000);
        n_checks++;
        if (l2_wb_valid !== 1'b1 || l2_wb_addr !== 32'h0) begin
            n_fail++; $display("FAIL ev_wb got v=%0b a=%h exp v=1 a=00000000", l2_wb_valid, l2_wb_addr);
        end
        n_checks++;
        if (l2_msg_valid !== 1'b1 || l2_msg_code !== 2'd0 || l2_msg_addr !== 32'h0080_0000) begin
            n_fail++; $display("FAIL ev_read got v=%0b c=%0d a=%h exp v=1 c=0 a=00800000", l2_msg_valid, l2_msg_code, l2_msg_addr);
        end
        do_cmd(4'd1, 32'h0080_0000);
        n_checks++;
        if (l2_msg_valid !== 1'b0 || l2_wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL ev_refill_e got msg=%0b wb=%0b exp 0 0", l2_msg_valid, l2_wb_valid);
        end
        n_checks++;
        if (d_reads !== 32'd8 || d_writes !== 32'd2 || d_hits !== 32'd1 || d_misses !== 32'd9) begin
            n_fail++; $display("FAIL ev_counters got r=%0d w=%0d h=%0d m=%0d exp 8 2 1 9", d_reads, d_writes, d_hits, d_misses);
        end
    endtask

    task automatic test_mesi();
        do_reset();
        do_cmd(4'd1, 32'h1000_0000);
        n_checks++;
        if (l2_msg_valid !== 1'b1 || l2_msg_code !== 2'd2 || l2_msg_addr !== 32'h1000_0000) begin
            n_fail++; $display("FAIL mesi_rfo got v=%0b c=%0d a=%h exp v=1 c=2 a=10000000", l2_msg_valid, l2_msg_code, l2_msg_addr);
        end
        do_cmd(4'd4, 32'h1000_0000);
        n_checks++;
        if (l2_msg_valid !== 1'b1 || l2_msg_code !== 2'd3 || l2_msg_addr !== 32'h1000_0000) begin
            n_fail++; $display("FAIL mesi_snoop_m got v=%0b c=%0d a=%h exp v=1 c=3 a=10000000", l2_msg_valid, l2_msg_code, l2_msg_addr);
        end
        do_cmd(4'd3, 32'h1000_0000);
        n_checks++;
        if (l2_msg_valid !== 1'b0 || d_writes !== 32'd1 || d_reads !== 32'd0 || d_misses !== 32'd1) begin
            n_fail++; $display("FAIL mesi_inval got msg=%0b w=%0d r=%0d m=%0d exp 0 1 0 1", l2_msg_valid, d_writes, d_reads, d_misses);
        end
        do_cmd(4'd0, 32'h1000_0000);
        n_checks++;
        if (d_misses !== 32'd2 || l2_msg_valid !== 1'b1 || l2_msg_code !== 2'd0) begin
            n_fail++; $display("FAIL mesi_after_inval got m=%0d v=%0b c=%0d exp m=2 v=1 c=0", d_misses, l2_msg_valid, l2_msg_code);
        end
        do_cmd(4'd4, 32'h1000_0000);
        n_checks++;
        if (l2_msg_valid !== 1'b0) begin
            n_fail++; $display("FAIL mesi_snoop_e got %0b exp 0", l2_msg_valid);
        end
        do_cmd(4'd1, 32'h1000_0000);
        n_checks++;
        if (l2_msg_valid !== 1'b1 || l2_msg_code !== 2'd1 || l2_msg_addr !== 32'h1000_0000 || d_hits !== 32'd1) begin
            n_fail++; $display("FAIL mesi_s_write got v=%0b c=%0d a=%h h=%0d exp v=1 c=1 a=10000000 h=1",
                               l2_msg_valid, l2_msg_code, l2_msg_addr, d_hits);
        end
        do_cmd(4'd1, 32'h1000_0000);
        n_checks++;
        if (l2_msg_valid !== 1'b0 || d_hits !== 32'd2) begin
            n_fail++; $display("FAIL mesi_m_write got v=%0b h=%0d exp v=0 h=2", l2_msg_valid, d_hits);
        end
        do_cmd(4'd0, 32'h3000_0000);
        do_cmd(4'd1, 32'h3000_0000);
        n_checks++;
        if (l2_msg_valid !== 1'b0 || d_hits !== 32'd3 || d_misses !== 32'd3) begin
            n_fail++; $display("FAIL mesi_e_to_m got v=%0b h=%0d m=%0d exp v=0 h=3 m=3", l2_msg_valid, d_hits, d_misses);
        end
        do_cmd(4'd3, 32'h3000_0000);
        do_cmd(4'd4, 32'h3000_0000);
        n_checks++;
        if (l2_msg_valid !== 1'b1 || l2_msg_code !== 2'd3) begin
            n_fail++; $display("FAIL mesi_inval_keeps_m got v=%0b c=%0d exp v=1 c=3", l2_msg_valid, l2_msg_code);
        end
    endtask

    task automatic test_split();
        do_reset();
        do_cmd(4'd2, 32'h2000_0000);
        n_checks++;
        if (l2_msg_valid !== 1'b1 || l2_msg_code !== 2'd0 || l2_msg_addr !== 32'h2000_0000) begin
            n_fail++; $display("FAIL split_imiss got v=%0b c=%0d a=%h exp v=1 c=0 a=20000000", l2_msg_valid, l2_msg_code, l2_msg_addr);
        end
        do_cmd(4'd2, 32'h2000_0000);
        do_cmd(4'd0, 32'h2000_0000);
        n_checks++;
        if (i_reads !== 32'd2 || i_hits !== 32'd1 || i_misses !== 32'd1 || d_misses !== 32'd1 || d_reads !== 32'd1) begin
            n_fail++; $display("FAIL split_counters got ir=%0d ih=%0d im=%0d dr=%0d dm=%0d exp 2 1 1 1 1",
                               i_reads, i_hits, i_misses, d_reads, d_misses);
        end
        for (int k = 1; k <= 4; k++) begin
            do_cmd(4'd2, 32'h2000_0000 | (k << 20));
            n_checks++;
            if (l2_wb_valid !== 1'b0 || l2_msg_valid !== 1'b1) begin
                n_fail++; $display("FAIL split_ievict_%0d got wb=%0b msg=%0b exp wb=0 msg=1", k, l2_wb_valid, l2_msg_valid);
            end
        end
        do_cmd(4'd2, 32'h2000_0000);
        n_checks++;
        if (i_misses !== 32'd6) begin
            n_fail++; $display("FAIL split_lru_evicted got im=%0d exp 6", i_misses);
        end
    endtask

    task automatic test_mode0();
        logic seen;
        do_reset();
        mode = 1'b0;
        seen = 1'b0;
        do_cmd(4'd1, 32'h0000_0000); seen |= l2_wb_valid | l2_msg_valid;
        for (int k = 1; k <= 8; k++) begin
            do_cmd(4'd0, k << 20); seen |= l2_wb_valid | l2_msg_valid;
        end
        do_cmd(4'd1, 32'h0080_0000); seen |= l2_wb_valid | l2_msg_valid;
        do_cmd(4'd4, 32'h0080_0000); seen |= l2_wb_valid | l2_msg_valid;
        do_cmd(4'd2, 32'h2000_0000); seen |= l2_wb_valid | l2_msg_valid;
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL mode0_quiet got %0b exp 0", seen);
        end
        n_checks++;
        if (d_reads !== 32'd8 || d_writes !== 32'd2 || d_hits !== 32'd1 || d_misses !== 32'd9 || i_misses !== 32'd1) begin
            n_fail++; $display("FAIL mode0_counters got r=%0d w=%0d h=%0d m=%0d im=%0d exp 8 2 1 9 1",
                               d_reads, d_writes, d_hits, d_misses, i_misses);
        end
        mode = 1'b1;
    endtask

    task automatic test_clear();
        do_cmd(4'd8, 32'h0);
        n_checks++;
        if ({d_reads, d_writes, d_hits, d_misses, i_reads, i_hits, i_misses} !== '0) begin
            n_fail++; $display("FAIL clear_counters got r=%0d m=%0d ir=%0d exp 0", d_reads, d_misses, i_reads);
        end
        do_cmd(4'd0, 32'h0080_0000);
        n_checks++;
        if (d_misses !== 32'd1 || l2_msg_valid !== 1'b1 || l2_wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear_next_miss got m=%0d msg=%0b wb=%0b exp m=1 msg=1 wb=0", d_misses, l2_msg_valid, l2_wb_valid);
        end
        do_cmd(4'd7, 32'h0080_0000);
        do_cmd(4'd9, 32'h0080_0000);
        n_checks++;
        if (d_reads !== 32'd1 || d_misses !== 32'd1 || l2_msg_valid !== 1'b0) begin
            n_fail++; $display("FAIL ignored_codes got r=%0d m=%0d msg=%0b exp 1 1 0", d_reads, d_misses, l2_msg_valid);
        end
        do_cmd(4'd0, 32'h0080_0000);
        n_checks++;
        if (d_hits !== 32'd1 || l2_msg_valid !== 1'b0) begin
            n_fail++; $display("FAIL ignored_keeps_line got h=%0d msg=%0b exp 1 0", d_hits, l2_msg_valid);
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_read_hit();
        test_evict();
        test_mesi();
        test_split();
        test_mode0();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
